// File: rtl/rtc_bus_responder.sv
// RTC-side responder for the multiplexed CS/RD/WR/A-D strobe bus: register file,
// pulse-width-qualified writes, 2-cycle-latency reads and a local timekeeping port.
module rtc_bus_responder #(
    parameter int         MIN_PULSE = 5,
    parameter logic [7:0] BASE_ADDR = 8'h20,
    parameter int         REG_COUNT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       a_d,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       wr_evt,
    output logic [3:0] evt_addr,
    output logic [7:0] evt_data,
    output logic       err,
    input  logic       lcl_we,
    input  logic [3:0] lcl_addr,
    input  logic [7:0] lcl_wdata,
    output logic [7:0] lcl_rdata
);
    typedef enum logic [1:0] {IDLE, WR_LOW, RD_LOW, ERR} state_t;

    localparam logic [5:0] MIN_CNT = 6'(MIN_PULSE);
    localparam logic [7:0] REG_LIM = 8'(REG_COUNT);

    state_t     state;
    logic       s_cs_n, s_rd_n, s_wr_n, s_a_d;
    logic [7:0] s_ad;
    logic [7:0] addr;
    logic [7:0] hold;
    logic       hold_phase;
    logic [5:0] cnt;
    logic [7:0] regs [REG_COUNT];

    logic [7:0] off;
    logic       in_range;
    logic [3:0] idx;
    logic [7:0] rd_val;
    logic [5:0] cnt_inc;

    always_comb begin
        off      = addr - BASE_ADDR;
        in_range = (addr >= BASE_ADDR) && (off < REG_LIM);
        idx      = off[3:0];
        rd_val   = in_range ? regs[idx] : 8'h00;
        cnt_inc  = (cnt == 6'd63) ? cnt : cnt + 6'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            s_cs_n     <= 1'b1;
            s_rd_n     <= 1'b1;
            s_wr_n     <= 1'b1;
            s_a_d      <= 1'b0;
            s_ad       <= '0;
            addr       <= '0;
            hold       <= '0;
            hold_phase <= 1'b0;
            cnt        <= '0;
            ad_out     <= '0;
            ad_oe      <= 1'b0;
            wr_evt     <= 1'b0;
            evt_addr   <= '0;
            evt_data   <= '0;
            err        <= 1'b0;
            lcl_rdata  <= '0;
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else begin
            s_cs_n    <= cs_n;
            s_rd_n    <= rd_n;
            s_wr_n    <= wr_n;
            s_a_d     <= a_d;
            s_ad      <= ad_in;
            wr_evt    <= 1'b0;
            err       <= 1'b0;
            lcl_rdata <= regs[lcl_addr];
            // Local write first so a same-cycle bus commit below overrides it.
            if (lcl_we) regs[lcl_addr] <= lcl_wdata;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!s_cs_n) begin
                        if (!s_rd_n && !s_wr_n) begin
                            state <= ERR;
                            err   <= 1'b1;
                        end else if (!s_wr_n) begin
                            state      <= WR_LOW;
                            cnt        <= 6'd1;
                            hold       <= s_ad;
                            hold_phase <= s_a_d;
                        end else if (!s_rd_n) begin
                            if (s_a_d) begin
                                state  <= RD_LOW;
                                cnt    <= 6'd1;
                                ad_out <= rd_val;
                                ad_oe  <= 1'b1;
                            end else begin
                                state <= ERR;
                                err   <= 1'b1;
                            end
                        end
                    end
                end
                WR_LOW: begin
                    if (s_cs_n) begin
                        state <= IDLE;
                        err   <= 1'b1;
                    end else if (!s_wr_n) begin
                        cnt        <= cnt_inc;
                        hold       <= s_ad;
                        hold_phase <= s_a_d;
                    end else begin
                        state <= IDLE;
                        if (cnt >= MIN_CNT) begin
                            if (!hold_phase) begin
                                addr <= hold;
                            end else if (in_range) begin
                                regs[idx] <= hold;
                                wr_evt    <= 1'b1;
                                evt_addr  <= idx;
                                evt_data  <= hold;
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                RD_LOW: begin
                    if (s_cs_n) begin
                        state <= IDLE;
                        ad_oe <= 1'b0;
                        err   <= 1'b1;
                    end else if (!s_rd_n) begin
                        cnt    <= cnt_inc;
                        ad_out <= rd_val;
                    end else begin
                        state <= IDLE;
                        ad_oe <= 1'b0;
                        if (cnt < MIN_CNT) err <= 1'b1;
                    end
                end
                default: begin
                    ad_oe <= 1'b0;
                    if (s_cs_n && s_rd_n && s_wr_n) state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rtc_bus_responder.sv
// Scoreboard bench for rtc_bus_responder: expected writes/reads queued at stimulus,
// popped when wr_evt pulses or ad_oe rises.
module tb_rtc_bus_responder;
    logic       clk = 1'b0;
    logic       reset;
    logic       cs_n, rd_n, wr_n, a_d;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       wr_evt;
    logic [3:0] evt_addr;
    logic [7:0] evt_data;
    logic       err;
    logic       lcl_we;
    logic [3:0] lcl_addr;
    logic [7:0] lcl_wdata;
    logic [7:0] lcl_rdata;

    int total = 0;
    int bad = 0;
    int err_seen = 0;
    int err_exp = 0;
    logic        prev_oe = 1'b0;
    logic [11:0] wr_q[$];
    logic [7:0]  rd_q[$];
    logic [7:0]  model_addr;
    logic [7:0]  model_regs [16];

    rtc_bus_responder dut (
        .clk(clk), .reset(reset), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d),
        .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .wr_evt(wr_evt),
        .evt_addr(evt_addr), .evt_data(evt_data), .err(err), .lcl_we(lcl_we),
        .lcl_addr(lcl_addr), .lcl_wdata(lcl_wdata), .lcl_rdata(lcl_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: pop scoreboard entries as the DUT produces them.
    always @(posedge clk) begin
        #1;
        if (err) err_seen++;
        if (wr_evt) begin
            if (wr_q.size() == 0) chk("wr_evt_unexpected", 1, 0);
            else begin
                logic [11:0] e;
                e = wr_q.pop_front();
                chk("evt_addr", {28'd0, evt_addr}, {28'd0, e[11:8]});
                chk("evt_data", {24'd0, evt_data}, {24'd0, e[7:0]});
            end
        end
        if (ad_oe && !prev_oe) begin
            if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
            else chk("rd_data", {24'd0, ad_out}, {24'd0, rd_q.pop_front()});
        end
        prev_oe = ad_oe;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic in_rng(input logic [7:0] a);
        return (a >= 8'h20) && (a < 8'h30);
    endfunction

    task automatic model_commit(input logic phase, input logic [7:0] data);
        logic [7:0] o;
        if (!phase) model_addr = data;
        else if (in_rng(model_addr)) begin
            o = model_addr - 8'h20;
            model_regs[o[3:0]] = data;
            wr_q.push_back({o[3:0], data});
        end
    endtask

    // Earlier low cycles carry ~data so only the last sampled value may be written.
    task automatic bus_write(input logic phase, input logic [7:0] data, input int n,
                             input logic collide);
        cs_n = 1'b0; a_d = phase; wr_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            ad_in = (i == n - 1) ? data : ~data;
            tick(1);
        end
        wr_n = 1'b1; ad_in = 8'h00;
        if (n >= 5) model_commit(phase, data);
        else err_exp++;
        tick(1);
        cs_n = 1'b1;
        if (collide) begin
            lcl_we = 1'b1; lcl_addr = 4'd1; lcl_wdata = 8'h77;
        end
        tick(1);
        lcl_we = 1'b0;
        tick(1);
    endtask

    task automatic bus_read(input int n);
        logic [7:0] o;
        o = model_addr - 8'h20;
        rd_q.push_back(in_rng(model_addr) ? model_regs[o[3:0]] : 8'h00);
        cs_n = 1'b0; a_d = 1'b1; rd_n = 1'b0;
        tick(1);
        chk("oe_before_latency", {31'd0, ad_oe}, 0);
        tick(1);
        chk("oe_after_latency", {31'd0, ad_oe}, 1);
        tick(n - 2);
        rd_n = 1'b1;
        tick(1);
        chk("oe_hold_after_rise", {31'd0, ad_oe}, 1);
        cs_n = 1'b1;
        tick(1);
        chk("oe_drop", {31'd0, ad_oe}, 0);
        tick(1);
    endtask

    task automatic lcl_read(input logic [3:0] i, input string tag);
        lcl_addr = i;
        tick(1);
        chk(tag, {24'd0, lcl_rdata}, {24'd0, model_regs[i]});
    endtask

    initial begin
        cs_n = 1; rd_n = 1; wr_n = 1; a_d = 0; ad_in = 0;
        lcl_we = 0; lcl_addr = 0; lcl_wdata = 0;
        model_addr = 0;
        for (int i = 0; i < 16; i++) model_regs[i] = 0;
        reset = 1'b0;
        tick(3);
        chk("rst_ad_oe", {31'd0, ad_oe}, 0);
        chk("rst_ad_out", {24'd0, ad_out}, 0);
        chk("rst_wr_evt", {31'd0, wr_evt}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_lcl_rdata", {24'd0, lcl_rdata}, 0);
        reset = 1'b1;
        tick(2);

        // Address + data write, then read back on both ports.
        bus_write(0, 8'h21, 5, 0);
        bus_write(1, 8'h59, 5, 0);
        tick(2);
        lcl_read(4'd1, "lcl_idx1_after_write");
        bus_read(5);
        chk("err_after_read", err_seen, err_exp);

        // Too-short data strobe: err, no commit.
        bus_write(1, 8'hE7, 3, 0);
        tick(2);
        chk("err_short_write", err_seen, err_exp);
        lcl_read(4'd1, "lcl_unchanged_short");

        // Both strobes low: single err, no drive, no commit.
        cs_n = 0; a_d = 1; rd_n = 0; wr_n = 0; ad_in = 8'h99;
        err_exp++;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("oe_both_low", {31'd0, ad_oe}, 0);
        end
        cs_n = 1; rd_n = 1; wr_n = 1;
        tick(3);
        chk("err_both_low", err_seen, err_exp);
        lcl_read(4'd1, "lcl_unchanged_both");

        // Out-of-range address: write ignored, read returns 0.
        bus_write(0, 8'h40, 5, 0);
        bus_write(1, 8'hAA, 5, 0);
        bus_read(5);

        // Local write then bus read of the same register.
        lcl_we = 1; lcl_addr = 4'd5; lcl_wdata = 8'hC3;
        model_regs[5] = 8'hC3;
        tick(1);
        lcl_we = 0;
        lcl_read(4'd5, "lcl_idx5");
        bus_write(0, 8'h25, 5, 0);
        bus_read(6);

        // Back-to-back data strobes with one high cycle between.
        bus_write(0, 8'h23, 5, 0);
        cs_n = 0; a_d = 1;
        for (int k = 0; k < 2; k++) begin
            wr_n = 0;
            ad_in = (k == 0) ? 8'h11 : 8'h22;
            tick(5);
            wr_n = 1;
            model_commit(1, ad_in);
            tick(1);
        end
        cs_n = 1;
        tick(3);
        lcl_read(4'd3, "lcl_idx3_b2b");

        // Same-cycle local and bus write to index 1: bus wins.
        bus_write(0, 8'h21, 5, 0);
        bus_write(1, 8'h3C, 5, 1);
        tick(1);
        lcl_read(4'd1, "lcl_collide_bus_wins");
        chk("err_mid", err_seen, err_exp);

        // Reset during RD_LOW.
        rd_q.push_back(model_regs[1]);
        cs_n = 0; a_d = 1; rd_n = 0;
        tick(2);
        chk("oe_before_reset", {31'd0, ad_oe}, 1);
        reset = 1'b0;
        tick(1);
        chk("mid_rst_ad_oe", {31'd0, ad_oe}, 0);
        chk("mid_rst_ad_out", {24'd0, ad_out}, 0);
        chk("mid_rst_evt_data", {24'd0, evt_data}, 0);
        chk("mid_rst_evt_addr", {28'd0, evt_addr}, 0);
        chk("mid_rst_err", {31'd0, err}, 0);
        chk("mid_rst_lcl_rdata", {24'd0, lcl_rdata}, 0);
        cs_n = 1; rd_n = 1;
        reset = 1'b1;
        model_addr = 0;
        for (int i = 0; i < 16; i++) model_regs[i] = 0;
        tick(3);
        chk("oe_after_reset", {31'd0, ad_oe}, 0);
        lcl_read(4'd1, "lcl_idx1_after_reset");
        lcl_read(4'd5, "lcl_idx5_after_reset");

        chk("err_total", err_seen, err_exp);
        chk("wr_q_left", wr_q.size(), 0);
        chk("rd_q_left", rd_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
